// File: rtl/imem_loader.sv
// imem_loader: loads a program image into the instruction RAM from a byte stream.
// The stream is a word count byte, the program words (high byte first) and a final
// XOR checksum byte. The core is held in reset while a load is in progress and is
// released only after the checksum matches.
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err
);

    // WRITE is the cycle after a LO handshake: the RAM strobe fires and no byte is taken.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        WRITE = 3'd4,
        CSUM  = 3'd5
    } state_t;

    localparam logic [8:0] DEPTH = 9'(1 << ADDR_WIDTH);

    state_t                state_q, state_d;
    logic [7:0]            hi_q, hi_d;
    logic [7:0]            csum_q, csum_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [8:0]            words_q, words_d;
    logic [8:0]            cnt_q, cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  load_done_q, load_done_d;
    logic                  load_err_q, load_err_d;
    logic                  handshake;
    logic [8:0]            n_len;

    assign in_ready  = (state_q == LEN) || (state_q == HI) ||
                       (state_q == LO)  || (state_q == CSUM);
    assign handshake = in_valid && in_ready;

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

    // Next-state logic: walks the stream format and prepares the registered outputs.
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        csum_d      = csum_q;
        addr_d      = addr_q;
        words_d     = words_q;
        cnt_d       = cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        cpu_hold_d  = cpu_hold_q;
        load_done_d = 1'b0;
        load_err_d  = load_err_q;
        n_len       = (in_data == 8'd0) ? DEPTH : {1'b0, in_data};

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    load_err_d = 1'b0;
                    csum_d     = 8'd0;
                    addr_d     = '0;
                    cnt_d      = 9'd0;
                    cpu_hold_d = 1'b1;
                    state_d    = LEN;
                end
            end
            LEN: begin
                if (handshake) begin
                    if (n_len > DEPTH) begin
                        load_err_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        words_d = n_len;
                        state_d = HI;
                    end
                end
            end
            HI: begin
                if (handshake) begin
                    hi_d    = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = LO;
                end
            end
            LO: begin
                if (handshake) begin
                    csum_d    = csum_q ^ in_data;
                    wr_en_d   = 1'b1;
                    wr_data_d = {hi_q, in_data};
                    wr_addr_d = addr_q;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                cnt_d   = cnt_q + 9'd1;
                state_d = (cnt_q + 9'd1 == words_q) ? CSUM : HI;
            end
            CSUM: begin
                if (handshake) begin
                    if (in_data == csum_q) begin
                        load_done_d = 1'b1;
                        cpu_hold_d  = 1'b0;
                    end else begin
                        load_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any load in progress and holds the core.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hi_q        <= 8'd0;
            csum_q      <= 8'd0;
            addr_q      <= '0;
            words_q     <= 9'd0;
            cnt_q       <= 9'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            csum_q      <= csum_d;
            addr_q      <= addr_d;
            words_q     <= words_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: randomized loads checked against a stream-level reference model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    logic        d4_start;
    logic [7:0]  d4_data;
    logic        d4_valid;
    logic        d4_ready;
    logic        d4_wr_en;
    logic [3:0]  d4_wr_addr;
    logic [15:0] d4_wr_data;
    logic        d4_hold;
    logic        d4_done;
    logic        d4_err;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    int d4_writes = 0;

    logic [23:0] obs_q[$];
    logic [23:0] exp_q[$];
    logic [15:0] words[$];

    imem_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
    );

    imem_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .load_start(d4_start), .in_data(d4_data),
        .in_valid(d4_valid), .in_ready(d4_ready), .wr_en(d4_wr_en), .wr_addr(d4_wr_addr),
        .wr_data(d4_wr_data), .cpu_hold(d4_hold), .load_done(d4_done), .load_err(d4_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Records every RAM write and load_done pulse seen on the main instance.
    always @(negedge clk) begin
        if (wr_en) begin
            obs_q.push_back({wr_addr, wr_data});
            checkOutput("ready_low_during_write", {31'd0, in_ready}, 32'd0);
        end
        if (load_done) done_pulses++;
        if (d4_wr_en) d4_writes++;
    end

    // Offers one byte after some idle cycles and waits for its handshake.
    task automatic sendByte(input logic [7:0] b, input int idle);
        int waited;
        repeat (idle) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) checkOutput("handshake_timeout", 32'd1, 32'd0);
        @(posedge clk);
    endtask

    // Streams one image built from 'words' and compares the outcome with the reference model.
    task automatic applyStimulus(input logic [7:0] count, input bit bad, input int stall_word);
        int          n;
        logic [7:0]  csum;
        logic [7:0]  idx;
        obs_q.delete();
        exp_q.delete();
        done_pulses = 0;
        n    = (count == 8'd0) ? 256 : int'(count);
        csum = 8'd0;
        @(negedge clk);
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 8'($urandom);
        @(negedge clk);
        load_start = 1'b0;
        in_valid   = 1'b0;
        checkOutput("start_clears_err", {31'd0, load_err}, 32'd0);
        sendByte(count, $urandom_range(0, 2));
        for (int k = 0; k < n; k++) begin
            idx = 8'(k);
            sendByte(words[k][15:8], $urandom_range(0, 2));
            sendByte(words[k][7:0], (k == stall_word) ? 5 : $urandom_range(0, 2));
            csum = csum ^ words[k][15:8] ^ words[k][7:0];
            exp_q.push_back({idx, words[k]});
        end
        @(negedge clk);
        in_valid   = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        sendByte(bad ? (csum ^ 8'h01) : csum, $urandom_range(0, 2));
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("write_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            checkOutput($sformatf("write_%0d", i), {8'd0, obs_q[i]}, {8'd0, exp_q[i]});
        checkOutput("load_done_pulses", done_pulses, bad ? 0 : 1);
        checkOutput("load_err", {31'd0, load_err}, {31'd0, bad});
        checkOutput("cpu_hold", {31'd0, cpu_hold}, {31'd0, bad});
        checkOutput("idle_ready", {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        d4_start = 1'b0; d4_valid = 1'b0; d4_data = 8'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("reset_wr_en", {31'd0, wr_en}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("reset_load_err", {31'd0, load_err}, 32'd0);
        checkOutput("reset_load_done", {31'd0, load_done}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed image: words 0x9208, 0xA248; checksum taken from the XOR rule
        words = '{16'h9208, 16'hA248};
        applyStimulus(8'd2, 1'b0, -1);
        applyStimulus(8'd2, 1'b1, 0);

        // Randomized images with occasional bad checksums and a 5-cycle stall
        for (int t = 0; t < 6; t++) begin
            int cnt;
            cnt = $urandom_range(1, 6);
            words.delete();
            for (int k = 0; k < cnt; k++) words.push_back(16'($urandom));
            applyStimulus(8'(cnt), ($urandom_range(0, 3) == 0), $urandom_range(0, cnt - 1));
        end

        // Full-depth image: count byte 0 means 256 words ending at address 0xFF
        words.delete();
        for (int k = 0; k < 256; k++) words.push_back(16'($urandom));
        applyStimulus(8'd0, 1'b0, 100);
        if (obs_q.size() > 0) checkOutput("last_addr", {24'd0, obs_q[obs_q.size()-1][23:16]}, 32'hFF);

        // Mid-load abort after the third byte
        obs_q.delete();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        sendByte(8'd3, 0);
        sendByte(8'h12, 0);
        sendByte(8'h34, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
        end
        checkOutput("abort_write_count", obs_q.size(), 1);
        if (obs_q.size() > 0) checkOutput("abort_write", {8'd0, obs_q[0]}, 32'h001234);
        checkOutput("abort_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("abort_wr_en", {31'd0, wr_en}, 32'd0);
        checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        words = '{16'h0000};
        applyStimulus(8'd1, 1'b0, -1);

        // Narrow instance: count 0x11 exceeds 16 entries, 0x10 is the largest legal count
        @(negedge clk);
        d4_start = 1'b1;
        @(negedge clk);
        d4_start = 1'b0; d4_valid = 1'b1; d4_data = 8'h11;
        @(negedge clk);
        d4_valid = 1'b0;
        checkOutput("d4_len_err", {31'd0, d4_err}, 32'd1);
        checkOutput("d4_idle", {31'd0, d4_ready}, 32'd0);
        checkOutput("d4_hold", {31'd0, d4_hold}, 32'd1);
        checkOutput("d4_no_writes", d4_writes, 0);
        @(negedge clk);
        d4_start = 1'b1;
        @(negedge clk);
        d4_start = 1'b0; d4_valid = 1'b1; d4_data = 8'h10;
        @(negedge clk);
        d4_valid = 1'b0;
        checkOutput("d4_len_ok_err", {31'd0, d4_err}, 32'd0);
        checkOutput("d4_len_ok_ready", {31'd0, d4_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
